och_pingpong_sched: RTL and testbench
=====================================

Name: och_pingpong_sched

Overview:
- Per-output-channel scheduler between the accelerator top FSM and the weight-load / conv engines.
- A two-slot (ping-pong) weight buffer lets the weights for channel k+1 load while channel k convolves.
- Issues start pulses with channel index and slot select to both engines and tracks slot occupancy.
- Reports progress and completion upward.

Parameters:
- CH_W, 8, width of channel count and indices.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- sched_start  input  1  pulse: begin a layer; accepted only when busy=0
- out_ch  input  CH_W  number of output channels; sampled at accepted sched_start
- busy  output  1  high from cycle after accepted start until done
- sched_done  output  1  one-cycle pulse: all channels convolved
- w_start  output  1  one-cycle pulse: load weights
- w_och  output  CH_W  channel to load; held until next w_start
- w_buf_sel  output  1  destination slot, = w_och[0]
- w_done  input  1  pulse: weight load complete
- c_start  output  1  one-cycle pulse: run conv for one channel
- c_och  output  CH_W  channel to convolve; held until next c_start
- c_buf_sel  output  1  source slot, = c_och[0]
- c_done  input  1  pulse: conv for c_och complete
- out_ch_cnt  output  CH_W  number of channels completed this layer

Behaviour:
- Reset: busy=0, sched_done=0, w_start=0, c_start=0, w_och=0, c_och=0, w_buf_sel=0, c_buf_sel=0, out_ch_cnt=0. All internal state also clears: slot_valid=00, load_idx=0, conv_idx=0, loading=0, convolving=0.
- Reset mid-layer aborts immediately; no pulses follow. Engines are reset by the same rst.
- Top states: IDLE and RUN.
- IDLE, sched_start=1 with out_ch>0: capture out_ch into och_r, clear indices and out_ch_cnt, go to RUN. busy=1 next cycle.
- IDLE, sched_start=1 with out_ch=0: sched_done pulses next cycle; no w_start or c_start; busy stays 0.
- sched_start while busy: ignored.
- Loader, in RUN: issues w_start when loading=0, load_idx<och_r, and slot load_idx[0] is free.
  - w_och=load_idx. Set loading.
  - On w_done while loading: slot_valid[w_buf_sel] set, load_idx++, loading cleared.
- Conv, in RUN: issues c_start when convolving=0, conv_idx<och_r, and slot conv_idx[0] is valid.
  - c_och=conv_idx. Set convolving.
  - On c_done while convolving: slot_valid[c_buf_sel] cleared, conv_idx++, out_ch_cnt++, convolving cleared.
- w_done without loading, or c_done without convolving: ignored.
- w_done and c_done in the same cycle: both updates apply. The two pulses always refer to different slots.
- Issue timing, all pulses registered:
  - Accepted sched_start in cycle t: w_start for och 0 in t+1.
  - w_done in t with conv idle: c_start in t+1. If load_idx+1<och_r and the other slot is free, w_start for the next channel also in t+1.
  - c_done in t: next c_start in t+1 if that slot is valid or becomes valid in t. w_start for the freed slot in t+1 if the loader is idle and channels remain.
- Completion: c_done in t with conv_idx+1==och_r:
  - sched_done=1 in t+1 for exactly one cycle.
  - busy=0 in t+1; top state returns to IDLE.
  - out_ch_cnt holds och_r until the next accepted start.
- Invariants checked by the bench:
  - Never two c_start without an intervening c_done.
  - Never a w_start to a valid slot.
  - load_idx-conv_idx is always in 0..2.
  - Channel indices wrap only at 2^CH_W. och_r ≤ 2^CH_W-1.

Optional Feature:
- Macro: OCH_SCHED_PERF_EN.
- Defined: adds output stall_cnt (16 bits, reset 0).
  - Increments each RUN cycle with convolving=0, conv_idx<och_r, and slot conv_idx[0] not valid.
  - Saturates at 16'hFFFF; clears at accepted sched_start.
- Not defined: port absent, no counter logic.

Test Plan:
- out_ch=3, w_done 4 cycles after each w_start, c_done 10 cycles after each c_start:
  - w_och 0,1,2 with w_buf_sel 0,1,0; c_och 0,1,2.
  - w_start(och2) occurs in the cycle after c_done(och0).
  - sched_done exactly once; out_ch_cnt=3.
- out_ch=1: one w_start, one c_start with c_buf_sel=0; sched_done one cycle after c_done; busy=0 the same cycle.
- out_ch=0: sched_done pulses one cycle after sched_start; busy stays 0; no w_start or c_start.
- out_ch=4 with w_done and c_done aligned into the same cycle: both slot updates are taken; no lost or duplicate starts; out_ch_cnt reaches 4.
- Stray pulses and restart attempts: w_done/c_done injected while idle are ignored; sched_start while busy does not change och_r.
- rst asserted mid-layer at channel 2 of 5: all outputs zero that cycle (async). A new start with out_ch=2 then runs cleanly from och 0.
- With OCH_SCHED_PERF_EN, out_ch=2, first w_done 6 cycles late: stall_cnt equals the measured c_start-waiting cycles.

Source files
------------

// File: rtl/och_pingpong_sched_if.sv
// och_pingpong_sched_if: scheduler bus between top FSM, weight loader and conv engine.
// Optional OCH_SCHED_PERF_EN adds the stall_cnt performance counter.
`default_nettype none

interface och_pingpong_sched_if #(
  parameter int CH_W = 8
);
  logic            sched_start;
  logic [CH_W-1:0] out_ch;
  logic            busy;
  logic            sched_done;
  logic            w_start;
  logic [CH_W-1:0] w_och;
  logic            w_buf_sel;
  logic            w_done;
  logic            c_start;
  logic [CH_W-1:0] c_och;
  logic            c_buf_sel;
  logic            c_done;
  logic [CH_W-1:0] out_ch_cnt;
`ifdef OCH_SCHED_PERF_EN
  logic [15:0]     stall_cnt;

  modport master (
    output sched_start, out_ch, w_done, c_done,
    input  busy, sched_done, w_start, w_och, w_buf_sel,
    input  c_start, c_och, c_buf_sel, out_ch_cnt, stall_cnt
  );
  modport slave (
    input  sched_start, out_ch, w_done, c_done,
    output busy, sched_done, w_start, w_och, w_buf_sel,
    output c_start, c_och, c_buf_sel, out_ch_cnt, stall_cnt
  );
`else
  modport master (
    output sched_start, out_ch, w_done, c_done,
    input  busy, sched_done, w_start, w_och, w_buf_sel,
    input  c_start, c_och, c_buf_sel, out_ch_cnt
  );
  modport slave (
    input  sched_start, out_ch, w_done, c_done,
    output busy, sched_done, w_start, w_och, w_buf_sel,
    output c_start, c_och, c_buf_sel, out_ch_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/och_pingpong_sched.sv
// och_pingpong_sched: per-output-channel ping-pong weight/conv scheduler.
// Optional macro OCH_SCHED_PERF_EN enables the 16-bit stall_cnt counter. Rev 1.0
`default_nettype none

module och_pingpong_sched #(
  parameter int CH_W = 8
) (
  input wire logic            clk,
  input wire logic            rst,
  och_pingpong_sched_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [CH_W-1:0] C_ONE = {{(CH_W-1){1'b0}}, 1'b1};

  logic [0:0]      r_state;
  logic [CH_W-1:0] r_och;
  logic [CH_W-1:0] r_load_idx;
  logic [CH_W-1:0] r_conv_idx;
  logic [CH_W-1:0] r_w_och;
  logic [CH_W-1:0] r_c_och;
  logic [CH_W-1:0] r_out_ch_cnt;
  logic [1:0]      r_slot_valid;
  logic            r_loading;
  logic            r_convolving;
  logic            r_busy;
  logic            r_sched_done;
  logic            r_w_start;
  logic            r_c_start;

  logic            w_run;
  logic            w_accept;
  logic            w_wdone;
  logic            w_cdone;
  logic            w_last;
  logic [1:0]      w_slot_nxt;
  logic [CH_W-1:0] w_load_nxt;
  logic [CH_W-1:0] w_conv_nxt;
  logic            w_loading_nxt;
  logic            w_conv_busy_nxt;
  logic            w_issue_w;
  logic            w_issue_c;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = (r_state == ST_IDLE) && bus.sched_start;
  assign w_wdone  = w_run && bus.w_done && r_loading;
  assign w_cdone  = w_run && bus.c_done && r_convolving;
  assign w_last   = w_cdone && ((r_conv_idx + C_ONE) == r_och);

  // Issue decisions look at the state after this cycle's done pulses so that a
  // freed or freshly loaded slot is reused in the very next cycle.
  always_comb begin
    w_slot_nxt = r_slot_valid;
    if (w_wdone) w_slot_nxt[r_load_idx[0]] = 1'b1;
    if (w_cdone) w_slot_nxt[r_conv_idx[0]] = 1'b0;
    w_load_nxt      = w_wdone ? (r_load_idx + C_ONE) : r_load_idx;
    w_conv_nxt      = w_cdone ? (r_conv_idx + C_ONE) : r_conv_idx;
    w_loading_nxt   = r_loading && !w_wdone;
    w_conv_busy_nxt = r_convolving && !w_cdone;
    w_issue_w = w_run && !w_last && !w_loading_nxt && (w_load_nxt < r_och)
                && !w_slot_nxt[w_load_nxt[0]];
    w_issue_c = w_run && !w_last && !w_conv_busy_nxt && (w_conv_nxt < r_och)
                && w_slot_nxt[w_conv_nxt[0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_och        <= '0;
      r_load_idx   <= '0;
      r_conv_idx   <= '0;
      r_w_och      <= '0;
      r_c_och      <= '0;
      r_out_ch_cnt <= '0;
      r_slot_valid <= 2'b00;
      r_loading    <= 1'b0;
      r_convolving <= 1'b0;
      r_busy       <= 1'b0;
      r_sched_done <= 1'b0;
      r_w_start    <= 1'b0;
      r_c_start    <= 1'b0;
    end else begin
      r_sched_done <= 1'b0;
      r_w_start    <= 1'b0;
      r_c_start    <= 1'b0;
      if (w_accept) begin
        r_out_ch_cnt <= '0;
        r_load_idx   <= '0;
        r_conv_idx   <= '0;
        r_slot_valid <= 2'b00;
        r_convolving <= 1'b0;
        if (bus.out_ch != '0) begin
          // Both slots are free at layer start, so channel 0 loads immediately.
          r_och     <= bus.out_ch;
          r_state   <= ST_RUN;
          r_busy    <= 1'b1;
          r_w_start <= 1'b1;
          r_w_och   <= '0;
          r_loading <= 1'b1;
        end else begin
          r_sched_done <= 1'b1;
          r_loading    <= 1'b0;
        end
      end else if (w_run) begin
        r_slot_valid <= w_slot_nxt;
        r_load_idx   <= w_load_nxt;
        r_conv_idx   <= w_conv_nxt;
        r_loading    <= w_loading_nxt || w_issue_w;
        r_convolving <= w_conv_busy_nxt || w_issue_c;
        if (w_cdone) r_out_ch_cnt <= r_out_ch_cnt + C_ONE;
        if (w_issue_w) begin
          r_w_start <= 1'b1;
          r_w_och   <= w_load_nxt;
        end
        if (w_issue_c) begin
          r_c_start <= 1'b1;
          r_c_och   <= w_conv_nxt;
        end
        if (w_last) begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_sched_done <= 1'b1;
        end
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.sched_done = r_sched_done;
  assign bus.w_start    = r_w_start;
  assign bus.w_och      = r_w_och;
  assign bus.w_buf_sel  = r_w_och[0];
  assign bus.c_start    = r_c_start;
  assign bus.c_och      = r_c_och;
  assign bus.c_buf_sel  = r_c_och[0];
  assign bus.out_ch_cnt = r_out_ch_cnt;

`ifdef OCH_SCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  // Conv engine idle with work remaining but its source slot not yet loaded.
  assign w_stall = w_run && !r_convolving && (r_conv_idx < r_och)
                   && !r_slot_valid[r_conv_idx[0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_accept) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_och_pingpong_sched.sv
// tb_och_pingpong_sched: randomized scoreboard bench for och_pingpong_sched.
`default_nettype none

module tb_och_pingpong_sched;
  localparam int CH_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  och_pingpong_sched_if #(.CH_W(CH_W)) bus();

  och_pingpong_sched #(.CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic eng_w = 1'b0, eng_c = 1'b0, stray_w = 1'b0, stray_c = 1'b0;
  assign bus.w_done = eng_w | stray_w;
  assign bus.c_done = eng_c | stray_c;

  int errors = 0;
  int checks = 0;
  int epoch  = 0;
  int w_lmin = 1, w_lmax = 8, c_lmin = 1, c_lmax = 8;

  int w_q[$];
  int c_q[$];
  int done_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge rst) epoch <= epoch + 1;

  // Weight-load engine model: one w_done per w_start after a random latency.
  initial begin
    int ep, lat;
    forever begin
      @(negedge clk);
      if (bus.w_start && !rst) begin
        ep  = epoch;
        lat = int'($urandom_range(w_lmax, w_lmin));
        repeat (lat) @(posedge clk);
        #1;
        if (ep == epoch && !rst) begin
          eng_w = 1'b1;
          @(posedge clk);
          #1 eng_w = 1'b0;
        end
      end
    end
  end

  initial begin
    int ep, lat;
    forever begin
      @(negedge clk);
      if (bus.c_start && !rst) begin
        ep  = epoch;
        lat = int'($urandom_range(c_lmax, c_lmin));
        repeat (lat) @(posedge clk);
        #1;
        if (ep == epoch && !rst) begin
          eng_c = 1'b1;
          @(posedge clk);
          #1 eng_c = 1'b0;
        end
      end
    end
  end

  // Reference model: layer-level bookkeeping of loaded/convolved channels and slot
  // occupancy; predicts every output for the following cycle.
  bit          m_busy, m_loading, m_conv_act, e_w, e_c, e_done;
  bit [1:0]    m_slot;
  int unsigned m_och, m_load, m_conv, m_wch, m_cch, m_cnt, m_stall;

  initial begin
    int v;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0; m_loading = 0; m_conv_act = 0; e_w = 0; e_c = 0; e_done = 0;
        m_slot = 2'b00; m_och = 0; m_load = 0; m_conv = 0; m_wch = 0; m_cch = 0;
        m_cnt = 0; m_stall = 0;
        w_q.delete(); c_q.delete(); done_q.delete();
        continue;
      end
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("w_start", 32'(bus.w_start), 32'(e_w));
      chk("c_start", 32'(bus.c_start), 32'(e_c));
      chk("sched_done", 32'(bus.sched_done), 32'(e_done));
      chk("w_och", 32'(bus.w_och), m_wch);
      chk("w_buf_sel", 32'(bus.w_buf_sel), m_wch % 2);
      chk("c_och", 32'(bus.c_och), m_cch);
      chk("c_buf_sel", 32'(bus.c_buf_sel), m_cch % 2);
      chk("out_ch_cnt", 32'(bus.out_ch_cnt), m_cnt);
`ifdef OCH_SCHED_PERF_EN
      chk("stall_cnt", 32'(bus.stall_cnt), m_stall);
`endif
      if (bus.w_start) begin
        if (w_q.size() == 0) chk("w_q_underflow", 32'd1, 32'd0);
        else begin v = w_q.pop_front(); chk("sb_w_och", 32'(bus.w_och), v); end
      end
      if (bus.c_start) begin
        if (c_q.size() == 0) chk("c_q_underflow", 32'd1, 32'd0);
        else begin v = c_q.pop_front(); chk("sb_c_och", 32'(bus.c_och), v); end
      end
      if (bus.sched_done) begin
        if (done_q.size() == 0) chk("done_q_underflow", 32'd1, 32'd0);
        else begin v = done_q.pop_front(); chk("sb_done_cnt", 32'(bus.out_ch_cnt), v); end
      end

      if (m_busy && !m_conv_act && m_conv < m_och && !m_slot[m_conv % 2] && m_stall != 65535)
        m_stall++;
      e_w = 0; e_c = 0; e_done = 0;
      if (!m_busy) begin
        if (bus.sched_start) begin
          m_stall = 0;
          m_cnt   = 0;
          if (bus.out_ch != 0) begin
            m_busy = 1; m_och = bus.out_ch; m_load = 0; m_conv = 0;
            m_slot = 2'b00; m_loading = 0; m_conv_act = 0;
          end else begin
            e_done = 1;
          end
        end
      end else begin
        if (bus.w_done && m_loading) begin
          m_slot[m_load % 2] = 1'b1; m_load++; m_loading = 0;
        end
        if (bus.c_done && m_conv_act) begin
          m_slot[m_conv % 2] = 1'b0; m_conv++; m_cnt++; m_conv_act = 0;
          if (m_conv == m_och) begin m_busy = 0; e_done = 1; end
        end
      end
      if (m_busy) begin
        if (!m_loading && m_load < m_och && !m_slot[m_load % 2]) begin
          e_w = 1; m_loading = 1; m_wch = m_load;
        end
        if (!m_conv_act && m_conv < m_och && m_slot[m_conv % 2]) begin
          e_c = 1; m_conv_act = 1; m_cch = m_conv;
        end
      end
    end
  end

  task automatic start_layer(input int n);
    @(posedge clk); #1;
    bus.sched_start = 1'b1;
    bus.out_ch      = CH_W'(n);
    for (int k = 0; k < n; k++) begin w_q.push_back(k); c_q.push_back(k); end
    done_q.push_back(n);
    @(posedge clk); #1;
    bus.sched_start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.sched_done) seen = 1;
    end
    chk("layer_done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic set_lat(input int wl0, input int wl1, input int cl0, input int cl1);
    w_lmin = wl0; w_lmax = wl1; c_lmin = cl0; c_lmax = cl1;
  endtask

  initial begin
    bit seen;
    bus.sched_start = 1'b0;
    bus.out_ch      = '0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_w_start", 32'(bus.w_start), 32'd0);
    chk("rst_c_start", 32'(bus.c_start), 32'd0);
    chk("rst_out_ch_cnt", 32'(bus.out_ch_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    set_lat(4, 4, 10, 10); start_layer(3); wait_done();
    set_lat(1, 8, 1, 8);   start_layer(1); wait_done();
    start_layer(0); wait_done();
    set_lat(4, 4, 4, 4);   start_layer(4); wait_done();

    @(posedge clk); #1 stray_w = 1'b1;
    @(posedge clk); #1 stray_w = 1'b0; stray_c = 1'b1;
    @(posedge clk); #1 stray_w = 1'b1;
    @(posedge clk); #1 stray_w = 1'b0; stray_c = 1'b0;

    set_lat(2, 6, 2, 6); start_layer(4);
    repeat (3) @(posedge clk);
    #1 bus.sched_start = 1'b1; bus.out_ch = 8'd1;
    @(posedge clk); #1 bus.sched_start = 1'b0;
    wait_done();

    set_lat(10, 10, 3, 3); start_layer(2); wait_done();

    set_lat(3, 3, 5, 5); start_layer(5);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (bus.c_start && bus.c_och == 8'd2) seen = 1;
    end
    chk("reach_ch2_timeout", 32'(seen), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_w_start", 32'(bus.w_start), 32'd0);
    chk("arst_c_start", 32'(bus.c_start), 32'd0);
    chk("arst_sched_done", 32'(bus.sched_done), 32'd0);
    chk("arst_w_och", 32'(bus.w_och), 32'd0);
    chk("arst_c_och", 32'(bus.c_och), 32'd0);
    chk("arst_c_buf_sel", 32'(bus.c_buf_sel), 32'd0);
    chk("arst_out_ch_cnt", 32'(bus.out_ch_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    set_lat(1, 8, 1, 8); start_layer(2); wait_done();

    for (int l = 0; l < 25; l++) begin
      set_lat(1, int'($urandom_range(8, 1)), 1, int'($urandom_range(8, 1)));
      start_layer(int'($urandom_range(6, 0)));
      wait_done();
    end

    repeat (12) @(posedge clk);
    chk("w_q_empty", 32'(w_q.size()), 32'd0);
    chk("c_q_empty", 32'(c_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
